param_buffer: RTL

- Parametrised successor of the 8-slot stall buffer.
- Circular-pointer FIFO of DATA_W-bit words, DEPTH entries deep. It sits between a pipeline stage and a shared-output arbiter.
- Raises arbiter_req while it holds data and pops one word per granted cycle onto a registered output.
- Adds over the previous generation: almost-full early warning, occupancy count, optional empty-bypass, and a sticky overflow flag.

---
 rtl/buffer_pkg.sv | 21 ++
 rtl/buffer_mem.sv | 32 +++
 rtl/param_buffer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/buffer_pkg.sv
// Shared helpers for the buffer family: counter/pointer widths and a
// pointer increment that wraps at DEPTH-1, so non-power-of-two depths work.
package buffer_pkg;

  // Width needed to hold an occupancy value in 0..depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width needed to address depth entries (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Next pointer value; depth-1 wraps to 0 instead of overflowing the field.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/buffer_mem.sv
// buffer_mem: DEPTH x DATA_W register array for the buffer family.
// Ports:
//   clk              write clock
//   wr_en            write wr_data into entry wr_addr on the rising edge
//   wr_addr/wr_data  write port
//   rd_addr          asynchronous read address
//   rd_data          contents of entry rd_addr (combinational)
// The array has no reset; a word is always written before it can be read.
module buffer_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_buffer.sv
// param_buffer: parametrised circular FIFO between a pipeline stage and a
// shared-output arbiter. Requests the arbiter while holding data and pops
// one word per granted cycle onto a registered output.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   inputs, in_valid   write data and its valid
//   arbiter_grant      output granted this cycle
//   flush              synchronous clear (beats everything but reset)
//   outputs, out_valid registered read data, one-cycle pulse per word
//   arbiter_req        count != 0
//   to_stall_mgmt      count == DEPTH
//   almost_full        count >= AF_THRESH
//   buffer_empty       count == 0
//   count              occupancy
//   overflow           sticky: a write was dropped while full
module param_buffer
  import buffer_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        inputs,
  input  logic                     in_valid,
  input  logic                     arbiter_grant,
  input  logic                     flush,
  output logic [DATA_W-1:0]        outputs,
  output logic                     out_valid,
  output logic                     arbiter_req,
  output logic                     to_stall_mgmt,
  output logic                     almost_full,
  output logic                     buffer_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam int unsigned PTR_W = ptr_w(DEPTH);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] rd_data;

  logic is_empty;
  logic is_full;
  logic pop;
  logic bypass;
  logic push;
  logic drop;

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);

  assign pop    = arbiter_grant && !is_empty;
  // Bypass only when empty, so a forwarded word can never overtake stored data.
  assign bypass = BYPASS_EN && arbiter_grant && is_empty && in_valid;
  // A pop in the same cycle frees the slot being written, so full+grant accepts.
  assign push   = in_valid && !bypass && (!is_full || pop);
  assign drop   = in_valid && is_full && !pop;

  buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !flush),
    .wr_addr (wr_ptr),
    .wr_data (inputs),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      outputs   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      outputs   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (pop) begin
        outputs <= rd_data;
        rd_ptr  <= PTR_W'(ptr_next(32'(rd_ptr), DEPTH));
      end else if (bypass) begin
        outputs <= inputs;
      end

      if (push) begin
        wr_ptr <= PTR_W'(ptr_next(32'(wr_ptr), DEPTH));
      end

      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end

      out_valid <= pop || bypass;

      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign arbiter_req   = !is_empty;
  assign buffer_empty  = is_empty;
  assign to_stall_mgmt = is_full;
  assign almost_full   = (count >= AF_CNT);

endmodule
